// File: rtl/crc_serial_engine.sv
// crc_serial_engine: parametrised bit-serial CRC engine.
//
// Absorbs a framed serial bit stream (valid/ready), steps a Galois LFSR per
// accepted bit, then emits the CRC_W-bit remainder LSB-first under an output
// handshake with backpressure. The remainder is also presented in parallel
// on crc_value, captured when the in_last beat is accepted.
//
// Optional feature: define CRC_CHECK_EN to add a receive-side check mode.
// A frame started with check_mode=1 is followed by CRC_W received CRC bits,
// which are compared against the remainder; crc_err_vld pulses once with the
// result on crc_err.
//
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous active-low reset
//   abort       synchronous frame abort (highest priority after reset)
//   in_valid    input bit present
//   in_data     serial data bit
//   in_last     final data bit of the frame
//   in_ready    engine accepts an input bit
//   out_valid   out_bit holds a CRC bit
//   out_ready   downstream accepts out_bit
//   out_bit     serial CRC bit, LSB first
//   out_last    final CRC bit
//   crc_value   parallel remainder
//   busy        high in every state except IDLE
//   check_mode  (CRC_CHECK_EN) frame is checked rather than generated
//   crc_err     (CRC_CHECK_EN) result of the last check
//   crc_err_vld (CRC_CHECK_EN) one-cycle strobe qualifying crc_err
module crc_serial_engine #(
  parameter int unsigned      CRC_W = 8,
  parameter logic [CRC_W-1:0] POLY  = 'h44,
  parameter logic [CRC_W-1:0] SEED  = 'hD8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             abort,
  input  logic             in_valid,
  input  logic             in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_bit,
  output logic             out_last,
  output logic [CRC_W-1:0] crc_value,
  output logic             busy
`ifdef CRC_CHECK_EN
  ,
  input  logic             check_mode,
  output logic             crc_err,
  output logic             crc_err_vld
`endif
);

  localparam int unsigned CNT_W = $clog2(CRC_W + 1);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] SHIFT_IN  = 2'd1;
  localparam logic [1:0] SHIFT_OUT = 2'd2;
`ifdef CRC_CHECK_EN
  localparam logic [1:0] CHECK     = 2'd3;
`endif

  logic [1:0]       state_q, state_d;
  logic [CRC_W-1:0] lfsr_q, lfsr_d;
  logic [CRC_W-1:0] crc_q, crc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             in_fire, out_fire, fb, cnt_end;
  logic [CRC_W-1:0] lfsr_step, lfsr_shr;
`ifdef CRC_CHECK_EN
  logic             mode_q, mode_d;
  logic             flag_q, flag_d;
  logic             err_q, err_d;
  logic             err_vld_q, err_vld_d;
  logic             frame_check, mis;
`endif

  // Outputs are pure state/register decode: no path from in_* to out_*.
  assign in_ready  = (state_q != SHIFT_OUT);
  assign out_valid = (state_q == SHIFT_OUT);
  assign busy      = (state_q != IDLE);
  assign out_bit   = lfsr_q[0];
  assign cnt_end   = (count_q == CNT_W'(CRC_W - 1));
  assign out_last  = out_valid & cnt_end;
  assign crc_value = crc_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign fb       = lfsr_q[0] ^ in_data;

  // Galois step: feedback enters the MSB and is XORed into tapped stages.
  assign lfsr_step = {fb, lfsr_q[CRC_W-1:1]} ^ ({1'b0, POLY[CRC_W-2:0]} & {CRC_W{fb}});
  assign lfsr_shr  = {1'b0, lfsr_q[CRC_W-1:1]};

`ifdef CRC_CHECK_EN
  // check_mode is only sampled on the first beat; later beats use the latch.
  assign frame_check = (state_q == IDLE) ? check_mode : mode_q;
  assign mis         = in_data ^ lfsr_q[0];
  assign crc_err     = err_q;
  assign crc_err_vld = err_vld_q;
`endif

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    count_d = count_q;
    crc_d   = crc_q;
`ifdef CRC_CHECK_EN
    mode_d    = mode_q;
    flag_d    = flag_q;
    err_d     = err_q;
    err_vld_d = 1'b0;
`endif
    if (abort) begin
      // Any beat offered alongside abort is dropped; crc_value is kept.
      state_d = IDLE;
      lfsr_d  = SEED;
      count_d = '0;
`ifdef CRC_CHECK_EN
      flag_d  = 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE, SHIFT_IN: begin
          if (in_fire) begin
            lfsr_d = lfsr_step;
`ifdef CRC_CHECK_EN
            if (state_q == IDLE) mode_d = check_mode;
`endif
            if (in_last) begin
              crc_d   = lfsr_step;
              count_d = '0;
              state_d = SHIFT_OUT;
`ifdef CRC_CHECK_EN
              if (frame_check) begin
                state_d = CHECK;
                flag_d  = 1'b0;
              end
`endif
            end else begin
              state_d = SHIFT_IN;
            end
          end
        end
        SHIFT_OUT: begin
          if (out_fire) begin
            if (cnt_end) begin
              state_d = IDLE;
              lfsr_d  = SEED;
              count_d = '0;
            end else begin
              lfsr_d  = lfsr_shr;
              count_d = count_q + CNT_W'(1);
            end
          end
        end
`ifdef CRC_CHECK_EN
        CHECK: begin
          if (in_fire) begin
            lfsr_d = lfsr_shr;
            flag_d = flag_q | mis;
            if (cnt_end) begin
              state_d   = IDLE;
              lfsr_d    = SEED;
              count_d   = '0;
              err_d     = flag_q | mis;
              err_vld_d = 1'b1;
              flag_d    = 1'b0;
            end else begin
              count_d = count_q + CNT_W'(1);
            end
          end
        end
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      lfsr_q    <= SEED;
      count_q   <= '0;
      crc_q     <= '0;
`ifdef CRC_CHECK_EN
      mode_q    <= 1'b0;
      flag_q    <= 1'b0;
      err_q     <= 1'b0;
      err_vld_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      count_q   <= count_d;
      crc_q     <= crc_d;
`ifdef CRC_CHECK_EN
      mode_q    <= mode_d;
      flag_q    <= flag_d;
      err_q     <= err_d;
      err_vld_q <= err_vld_d;
`endif
    end
  end

endmodule

// File: tb/tb_crc_serial_engine.sv
// Self-checking bench for crc_serial_engine. Two instances run side by side:
// index 0 uses SEED=0, index 1 the default SEED=8'hD8. Expected remainders
// are hand-computed for POLY=8'h44.
module tb_crc_serial_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] abort, in_valid, in_data, in_last, out_ready;
  logic [1:0] in_ready, out_valid, out_bit, out_last, busy;
  logic [7:0] crc_value [2];
`ifdef CRC_CHECK_EN
  logic [1:0] check_mode, crc_err, crc_err_vld;
`endif

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  crc_serial_engine #(.CRC_W(8), .POLY(8'h44), .SEED(8'h00)) u_dut0 (
    .clk       (clk),
    .rst       (rst),
    .abort     (abort[0]),
    .in_valid  (in_valid[0]),
    .in_data   (in_data[0]),
    .in_last   (in_last[0]),
    .in_ready  (in_ready[0]),
    .out_valid (out_valid[0]),
    .out_ready (out_ready[0]),
    .out_bit   (out_bit[0]),
    .out_last  (out_last[0]),
    .crc_value (crc_value[0]),
    .busy      (busy[0])
`ifdef CRC_CHECK_EN
    ,
    .check_mode  (check_mode[0]),
    .crc_err     (crc_err[0]),
    .crc_err_vld (crc_err_vld[0])
`endif
  );

  crc_serial_engine #(.CRC_W(8)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .abort     (abort[1]),
    .in_valid  (in_valid[1]),
    .in_data   (in_data[1]),
    .in_last   (in_last[1]),
    .in_ready  (in_ready[1]),
    .out_valid (out_valid[1]),
    .out_ready (out_ready[1]),
    .out_bit   (out_bit[1]),
    .out_last  (out_last[1]),
    .crc_value (crc_value[1]),
    .busy      (busy[1])
`ifdef CRC_CHECK_EN
    ,
    .check_mode  (check_mode[1]),
    .crc_err     (crc_err[1]),
    .crc_err_vld (crc_err_vld[1])
`endif
  );

  typedef struct {
    int         d;     // instance index
    int         n;     // frame length in bits
    logic [7:0] bits;  // bit k is the k-th data bit
    logic [7:0] crc;   // expected remainder
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers n bits back to back; in_last on the final one when with_last=1.
  task automatic send_bits(input int d, input int n, input logic [7:0] bits,
                           input logic with_last);
    for (int k = 0; k < n; k++) begin
      in_valid[d] = 1'b1;
      in_data[d]  = bits[k];
      in_last[d]  = with_last && (k == n - 1);
      tick();
    end
    in_valid[d] = 1'b0;
    in_last[d]  = 1'b0;
    in_data[d]  = 1'b0;
  endtask

  // Collects 8 output cycles with out_ready high and checks the whole burst.
  task automatic collect_out(input int d, input logic [7:0] exp, input string name);
    logic [7:0] got, lasts;
    int         vcnt, ircnt;
    got   = '0;
    lasts = '0;
    vcnt  = 0;
    ircnt = 0;
    out_ready[d] = 1'b1;
    for (int j = 0; j < 8; j++) begin
      got[j]   = out_bit[d];
      lasts[j] = out_last[d];
      vcnt    += int'(out_valid[d]);
      ircnt   += int'(in_ready[d]);
      tick();
    end
    check({name, " out_bits"}, got, exp);
    check({name, " out_last"}, lasts, 8'h80);
    check({name, " valid_cycles"}, vcnt, 8);
    check({name, " in_ready_low"}, ircnt, 0);
    check({name, " idle_after"}, {busy[d], in_ready[d], out_valid[d]}, 3'b010);
  endtask

`ifdef CRC_CHECK_EN
  // Check-mode frame on instance 0: data bit 1, then 8 received CRC bits.
  task automatic check_frame(input logic [7:0] tail, input logic exp_err, input string name);
    int ov, ev;
    ov = 0;
    ev = 0;
    check_mode[0] = 1'b1;
    in_valid[0]   = 1'b1;
    in_data[0]    = 1'b1;
    in_last[0]    = 1'b1;
    tick();
    in_last[0]    = 1'b0;
    check_mode[0] = 1'b0;
    check({name, " crc_value"}, crc_value[0], 8'hC4);
    for (int j = 0; j < 8; j++) begin
      ov += int'(out_valid[0]);
      ev += int'(crc_err_vld[0]);
      check({name, " in_ready"}, in_ready[0], 1'b1);
      in_data[0] = tail[j];
      tick();
    end
    in_valid[0] = 1'b0;
    in_data[0]  = 1'b0;
    check({name, " no_out_valid"}, ov, 0);
    check({name, " no_early_vld"}, ev, 0);
    check({name, " err_vld"}, crc_err_vld[0], 1'b1);
    check({name, " err"}, crc_err[0], exp_err);
    check({name, " idle"}, busy[0], 1'b0);
    tick();
    check({name, " vld_pulse"}, crc_err_vld[0], 1'b0);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{d: 0, n: 1, bits: 8'b001, crc: 8'hC4};
    vecs[1]  = '{d: 1, n: 1, bits: 8'b000, crc: 8'h6C};
    vecs[2]  = '{d: 0, n: 2, bits: 8'b001, crc: 8'h62};
    vecs[3]  = '{d: 0, n: 2, bits: 8'b011, crc: 8'hA6};
    vecs[4]  = '{d: 0, n: 2, bits: 8'b010, crc: 8'hC4};
    vecs[5]  = '{d: 1, n: 1, bits: 8'b001, crc: 8'hA8};
    vecs[6]  = '{d: 1, n: 2, bits: 8'b000, crc: 8'h36};
    vecs[7]  = '{d: 1, n: 2, bits: 8'b001, crc: 8'h54};
    vecs[8]  = '{d: 1, n: 2, bits: 8'b010, crc: 8'hF2};
    vecs[9]  = '{d: 0, n: 1, bits: 8'b000, crc: 8'h00};
    vecs[10] = '{d: 0, n: 3, bits: 8'b111, crc: 8'h97};

    rst       = 1'b0;
    abort     = '0;
    in_valid  = '0;
    in_data   = '0;
    in_last   = '0;
    out_ready = 2'b11;
`ifdef CRC_CHECK_EN
    check_mode = '0;
`endif

    // Reset state.
    #12;
    for (int d = 0; d < 2; d++) begin
      check("reset out_valid", out_valid[d], 1'b0);
      check("reset out_last", out_last[d], 1'b0);
      check("reset busy", busy[d], 1'b0);
      check("reset crc_value", crc_value[d], 8'h00);
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("post_reset in_ready0", in_ready[0], 1'b1);
    check("post_reset in_ready1", in_ready[1], 1'b1);

    // Table-driven frames, out_ready tied high.
    for (int i = 0; i < 11; i++) begin
      send_bits(vecs[i].d, vecs[i].n, vecs[i].bits, 1'b1);
      check($sformatf("vec%0d crc_value", i), crc_value[vecs[i].d], vecs[i].crc);
      check($sformatf("vec%0d out_valid_rise", i), out_valid[vecs[i].d], 1'b1);
      collect_out(vecs[i].d, vecs[i].crc, $sformatf("vec%0d", i));
    end

    // Backpressure: stall 5 cycles while an input beat is offered and ignored.
    send_bits(0, 1, 8'b1, 1'b1);
    out_ready[0] = 1'b0;
    in_valid[0]  = 1'b1;
    in_data[0]   = 1'b1;
    in_last[0]   = 1'b1;
    for (int s = 0; s < 5; s++) begin
      tick();
      check("stall out_bit", out_bit[0], 1'b0);
      check("stall out_last", out_last[0], 1'b0);
      check("stall out_valid", out_valid[0], 1'b1);
      check("stall in_ready", in_ready[0], 1'b0);
    end
    in_valid[0] = 1'b0;
    in_data[0]  = 1'b0;
    in_last[0]  = 1'b0;
    check("stall crc_value", crc_value[0], 8'hC4);
    collect_out(0, 8'hC4, "stall_resume");

    // Abort at the third output bit of the default-seed frame.
    send_bits(1, 1, 8'b0, 1'b1);
    tick();
    tick();
    check("abort third_bit", out_bit[1], 1'b1);
    abort[1]    = 1'b1;
    in_valid[1] = 1'b1;
    in_data[1]  = 1'b1;
    in_last[1]  = 1'b1;
    tick();
    abort[1]    = 1'b0;
    in_valid[1] = 1'b0;
    check("abort state", {busy[1], in_ready[1], out_valid[1], out_last[1]}, 4'b0100);
    check("abort crc_kept", crc_value[1], 8'h6C);
    // Abort in IDLE drops a concurrent one-bit frame.
    abort[1]    = 1'b1;
    in_valid[1] = 1'b1;
    tick();
    abort[1]    = 1'b0;
    in_valid[1] = 1'b0;
    in_data[1]  = 1'b0;
    in_last[1]  = 1'b0;
    check("abort drop busy", busy[1], 1'b0);
    check("abort drop crc", crc_value[1], 8'h6C);
    send_bits(1, 1, 8'b0, 1'b1);
    check("after_abort crc_value", crc_value[1], 8'h6C);
    collect_out(1, 8'h6C, "after_abort");

    // Asynchronous reset four bits into a frame.
    send_bits(1, 4, 8'b1010, 1'b0);
    check("midframe busy", busy[1], 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check("async busy", busy[1], 1'b0);
    check("async out_valid", out_valid[1], 1'b0);
    check("async out_last", out_last[1], 1'b0);
    check("async crc_value1", crc_value[1], 8'h00);
    check("async crc_value0", crc_value[0], 8'h00);
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("release in_ready", in_ready[1], 1'b1);
    send_bits(1, 1, 8'b0, 1'b1);
    check("after_reset crc_value", crc_value[1], 8'h6C);
    collect_out(1, 8'h6C, "after_reset");

`ifdef CRC_CHECK_EN
    check_frame(8'b1100_0100, 1'b0, "check_good");
    check_frame(8'b0100_0100, 1'b1, "check_bad");
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/crc_serial_engine.md
Name: crc_serial_engine

Overview:
Parametrised bit-serial CRC engine, successor to the fixed 8-bit serial CRC generator. Absorbs a framed serial bit stream under a valid/ready handshake, then emits the CRC_W-bit remainder LSB-first under an output handshake with backpressure. Also presents the remainder in parallel. Sits between the serial framer and the line encoder in the TX path; the optional check mode serves the RX path.

Parameters:
- CRC_W, 8, CRC width in bits; legal range 2..32.
- POLY, 8'h44, Galois tap mask. Bit i=1 XORs the feedback into stage i, for i in 0..CRC_W-2. Bit CRC_W-1 is ignored.
- SEED, 8'hD8, LFSR preset loaded at reset, at frame start and on abort.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- abort  in  1  synchronous frame abort.
- in_valid  in  1  input bit present.
- in_data  in  1  serial data bit.
- in_last  in  1  marks the final data bit of the frame; qualified by in_valid.
- in_ready  out  1  engine accepts an input bit.
- out_valid  out  1  out_bit holds a CRC bit.
- out_ready  in  1  downstream accepts out_bit.
- out_bit  out  1  serial CRC bit, LSB first.
- out_last  out  1  marks the final CRC bit.
- crc_value  out  CRC_W  parallel remainder; updated when in_last is accepted.
- busy  out  1  high in every state except IDLE.

Behaviour:
- One clock domain. Reset is asynchronous, active-low, on port rst.
- Reset values: lfsr=SEED, state=IDLE, out_valid=0, out_last=0, crc_value=0, count=0, busy=0. in_ready=1 once reset is released.
- Input beat: accepted when in_valid & in_ready. Output beat: transfers when out_valid & out_ready.
- LFSR step on each accepted input beat:
  - fb = lfsr[0] ^ in_data
  - lfsr[CRC_W-1] <= fb
  - lfsr[i] <= lfsr[i+1] ^ (POLY[i] & fb), for i < CRC_W-1
- Counter: count is $clog2(CRC_W+1) bits wide.
- States:
  - IDLE: in_ready=1. An accepted beat steps the LFSR from its current value, which always equals SEED in IDLE. Next state is SHIFT_IN, or SHIFT_OUT if in_last=1 (a one-bit frame is legal).
  - SHIFT_IN: in_ready=1. Each accepted beat steps the LFSR. A beat with in_last=1 moves to SHIFT_OUT. It also registers the post-step LFSR value into crc_value and clears count. With no beat, the state holds.
  - SHIFT_OUT: in_ready=0, out_valid=1, out_bit=lfsr[0], out_last=(count==CRC_W-1).
    - Each output beat shifts lfsr right with zero fill at the MSB and increments count.
    - The beat with out_last=1 goes to IDLE and reloads lfsr=SEED.
    - With out_ready=0, out_bit, out_last and count hold indefinitely.
- Latency: out_valid rises on the cycle after the in_last beat is accepted. With out_ready tied high, exactly CRC_W output cycles follow.
- Outputs are driven from registers or state decode only. There is no combinational path from in_* to out_*.
- abort=1 (after reset, highest priority):
  - next state IDLE, lfsr=SEED, out_valid=0, out_last=0;
  - crc_value keeps its last value;
  - any input beat offered in the same cycle is dropped.
- in_data and in_last are ignored when in_valid=0. in_valid is ignored whenever in_ready=0.
- crc_value stays stable until the next in_last beat is accepted.
- Reset asserted mid-frame clears all state immediately. No partial CRC is emitted.

Optional Feature:
Macro CRC_CHECK_EN.
- When defined, the block gains:
  - input check_mode (sampled only on the first beat of a frame),
  - outputs crc_err and crc_err_vld.
- In check mode, the in_last beat moves to CHECK instead of SHIFT_OUT.
  - CHECK keeps in_ready=1 and consumes CRC_W further input bits.
  - Each bit is compared against lfsr[0], then lfsr shifts right with zero fill.
  - Any mismatch sets a sticky error flag.
- After the CRC_W-th bit: crc_err_vld pulses for 1 cycle, crc_err=flag, and the state returns to IDLE with lfsr=SEED. out_valid stays 0 throughout.
- abort clears the flag.
- When not defined, those ports and the CHECK state do not exist, and every frame generates.

Test Plan:
1. SEED=0: single beat in_data=1, in_last=1; out_ready=1 -> crc_value=8'hC4. out_bit sequence 0,0,1,0,0,0,1,1; out_last on the 8th bit; next cycle busy=0, in_ready=1.
2. Default SEED=8'hD8: single beat in_data=0, in_last=1 -> crc_value=8'h6C. Bits 0,0,1,1,0,1,1,0.
3. Backpressure: scenario 1 with out_ready=0 for 5 cycles after out_valid rises -> out_bit=0 and count hold. The sequence resumes unchanged and in_ready stays 0 throughout.
4. abort asserted at the 3rd output bit of scenario 2 -> next cycle out_valid=0, state IDLE, lfsr=8'hD8. A new 1-bit frame with in_data=0 again yields 8'h6C.
5. Reset asserted mid-SHIFT_IN, 4 bits into a frame -> all outputs take their reset values asynchronously, with no clock edge required. After release, in_ready=1.
6. CRC_CHECK_EN, SEED=0, check_mode=1:
   - Frame bit 1 with in_last, then bits 0,0,1,0,0,0,1,1 -> crc_err_vld pulse with crc_err=0.
   - Flip the last bit -> crc_err=1.
